regbus_seq_initiator: RTL and testbench
=======================================

REGBUS_SEQ_INITIATOR -- requirements
Module: regbus_seq_initiator

Interface
REQ-001: Parameter AddrWidth, default 48, reg-bus address width.
REQ-002: Parameter DataWidth, default 32, reg-bus data width; StrbWidth = DataWidth/8.
REQ-003: Parameter TimeoutCycles, default 1024, max cycles a request waits for ready; 0 disables timeout.
REQ-004: Parameter req_t, default reg_a48_d32_req_t, reg-bus request struct (addr, write, wdata, wstrb, valid).
REQ-005: Parameter rsp_t, default reg_a48_d32_rsp_t, reg-bus response struct (rdata, error, ready).
REQ-006: clk_i  in  1  single clock; all logic rising-edge.
REQ-007: rst_i  in  1  synchronous active-high reset.
REQ-008: cmd_valid_i  in  1  command offered.
REQ-009: cmd_ready_o  out  1  command accepted when both high.
REQ-010: cmd_addr_i  in  AddrWidth  target address.
REQ-011: cmd_write_i  in  1  1 = write, 0 = read.
REQ-012: cmd_wdata_i  in  DataWidth  write data.
REQ-013: cmd_wstrb_i  in  StrbWidth  write byte enables.
REQ-014: reg_req_o  out  req_t  reg-bus request to responder.
REQ-015: reg_rsp_i  in  rsp_t  reg-bus response from responder.
REQ-016: rsp_valid_o  out  1  result available.
REQ-017: rsp_ready_i  in  1  result consumed when both high.
REQ-018: rsp_rdata_o  out  DataWidth  read data; 0 for writes and timeouts.
REQ-019: rsp_error_o  out  1  responder error or timeout.
REQ-020: rsp_timeout_o  out  1  transaction aborted by timeout.
REQ-021: busy_o  out  1  high whenever state is not IDLE.

Function
REQ-022: FSM states IDLE, BUSY, RESP; cmd_ready_o = (state == IDLE).
REQ-023: IDLE: on cmd handshake, register addr/write/wdata/wstrb (wstrb forced all-ones for reads), clear timeout counter, go BUSY.
REQ-024: BUSY: reg_req_o.valid = 1 with registered fields held stable; all request fields zero outside BUSY.
REQ-025: BUSY and reg_rsp_i.ready: capture rdata (reads only, else 0) and error, timeout flag 0, go RESP; request is single-beat, completes in that cycle.
REQ-026: BUSY, no ready: counter increments; when counter reaches TimeoutCycles-1 (TimeoutCycles > 0) the transfer ends: valid drops next cycle, capture rdata 0, error 1, timeout 1, go RESP.
REQ-027: ready and timeout in same cycle: ready wins, normal completion.
REQ-028: RESP: rsp_valid_o = 1, outputs stable until rsp_ready_i; on handshake go IDLE.
REQ-029: Latency: cmd handshake in cycle N -> reg valid in N+1; ready in cycle M -> rsp_valid_o in M+1; new cmd acceptable the cycle after rsp handshake.
REQ-030: One outstanding transaction; no command buffering; cmd_valid_i ignored outside IDLE.
REQ-031: Timeout counter width $clog2(TimeoutCycles+1), saturating, never wraps.
REQ-032: reg_rsp_i ignored in IDLE and RESP.

Reset
REQ-033: With rst_i high at a rising edge: state IDLE, counter 0, captured data/flags 0.
REQ-034: Reset values: cmd_ready_o 1 (after reset released), reg_req_o all zero, rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, rsp_timeout_o 0, busy_o 0.
REQ-035: Reset mid-BUSY abandons the transfer: valid low in the cycle after the reset edge, no response produced.

Structure
REQ-036: Package regbus_seq_initiator_pkg holds the state enum (IDLE, BUSY, RESP) and the response struct (rdata, error, timeout).
REQ-037: No sub-module; the timeout counter and FSM are inline, single always_ff block for state plus combinational output decode.

Verification
REQ-038: Read 0x1000 with responder ready immediately, rdata 0xDEADBEEF -> valid for exactly 1 cycle, rsp rdata 0xDEADBEEF, error 0, timeout 0, 2 cycles cmd-to-rsp.
REQ-039: Write 0x2004 wdata 0x12345678 wstrb 0x3, responder ready after 5 cycles -> req fields stable for 6 cycles, rsp rdata 0, error 0.
REQ-040: TimeoutCycles=16, responder never ready -> valid high exactly 16 cycles, rsp error 1, timeout 1, rdata 0.
REQ-041: TimeoutCycles=16, ready asserted in 16th BUSY cycle -> normal completion, timeout 0.
REQ-042: rsp_ready_i held low 10 cycles -> rsp fields stable, cmd_ready_o 0 throughout, second cmd accepted the cycle after rsp handshake.
REQ-043: rst_i pulsed in 3rd BUSY cycle -> valid 0 next cycle, rsp_valid_o never asserts, busy_o 0, cmd_ready_o 1 after release.

Source files
------------

// File: rtl/regbus_seq_initiator_pkg.sv
// Shared types for the reg-bus sequence initiator: FSM states, captured response,
// and the default 48-bit address / 32-bit data reg-bus request/response structs.
package regbus_seq_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Captured rdata is sized for the widest supported bus; narrower buses use the low bits.
    localparam int unsigned MaxDataWidth = 128;

    typedef struct packed {
        logic [MaxDataWidth-1:0] rdata;
        logic                    error;
        logic                    timeout;
    } seq_rsp_t;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_a48_d32_rsp_t;

endpackage

// File: rtl/regbus_seq_initiator.sv
// Single-outstanding reg-bus initiator: accepts one command, drives it on the reg bus
// until the responder is ready or a timeout expires, then holds the result until consumed.
module regbus_seq_initiator
    import regbus_seq_initiator_pkg::*;
#(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         req_t         = reg_a48_d32_req_t,
    parameter type         rsp_t         = reg_a48_d32_rsp_t,
    localparam int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_write_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    input  logic [StrbWidth-1:0] cmd_wstrb_i,
    output req_t                 reg_req_o,
    input  rsp_t                 reg_rsp_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 rsp_timeout_o,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] wstrb_q;
    logic [CntWidth-1:0]  cnt_q;
    seq_rsp_t             cap_q;
    logic                 timeout_hit;

    assign timeout_hit = (TimeoutCycles > 0) && (cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid_i) begin
                addr_q  <= cmd_addr_i;
                write_q <= cmd_write_i;
                wdata_q <= cmd_wdata_i;
                wstrb_q <= cmd_write_i ? cmd_wstrb_i : '1;
                cnt_q   <= '0;
            end
            if (state_q == BUSY) begin
                // A ready in the timeout cycle still completes normally.
                if (reg_rsp_i.ready) begin
                    cap_q.rdata   <= write_q ? '0 : MaxDataWidth'(reg_rsp_i.rdata);
                    cap_q.error   <= reg_rsp_i.error;
                    cap_q.timeout <= 1'b0;
                end else if (timeout_hit) begin
                    cap_q.rdata   <= '0;
                    cap_q.error   <= 1'b1;
                    cap_q.timeout <= 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CntWidth'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = BUSY;
            BUSY:    if (reg_rsp_i.ready || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_req_o = '0;
        if (state_q == BUSY) begin
            reg_req_o.addr  = addr_q;
            reg_req_o.write = write_q;
            reg_req_o.wdata = wdata_q;
            reg_req_o.wstrb = wstrb_q;
            reg_req_o.valid = 1'b1;
        end
        cmd_ready_o   = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        rsp_valid_o   = (state_q == RESP);
        rsp_rdata_o   = cap_q.rdata[DataWidth-1:0];
        rsp_error_o   = cap_q.error;
        rsp_timeout_o = cap_q.timeout;
    end

endmodule

// File: tb/tb_regbus_seq_initiator.sv
// Directed plus randomized bench for regbus_seq_initiator with a 16-cycle timeout;
// expected results come from a transaction-level model of ready delay vs. timeout.
module tb_regbus_seq_initiator;
    import regbus_seq_initiator_pkg::*;

    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [47:0]      cmd_addr_i;
    logic             cmd_write_i;
    logic [31:0]      cmd_wdata_i;
    logic [3:0]       cmd_wstrb_i;
    reg_a48_d32_req_t reg_req_o;
    reg_a48_d32_rsp_t reg_rsp_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_error_o;
    logic             rsp_timeout_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbus_seq_initiator #(
        .AddrWidth(48), .DataWidth(32), .TimeoutCycles(TO),
        .req_t(reg_a48_d32_req_t), .rsp_t(reg_a48_d32_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_noise_cmd();
        cmd_addr_i  = {$urandom, $urandom};
        cmd_write_i = 1'($urandom);
        cmd_wdata_i = $urandom;
        cmd_wstrb_i = 4'($urandom);
    endtask

    // Called just after a negedge with the DUT idle; returns just after the negedge
    // following the response handshake. delay = BUSY cycles without ready before ready.
    task automatic run_txn(input logic [47:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int delay, input logic [31:0] rdata,
                           input logic err, input int hold);
        int          nvld = 0;
        int          exp_n;
        logic        exp_to;
        logic [31:0] exp_rdata;
        logic        exp_err;
        exp_to    = (delay + 1 > TO);
        exp_n     = exp_to ? TO : delay + 1;
        exp_rdata = (exp_to || wr) ? 32'h0 : rdata;
        exp_err   = exp_to ? 1'b1 : err;

        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_addr_i = addr; cmd_write_i = wr;
        cmd_wdata_i = wdata; cmd_wstrb_i = wstrb;
        @(posedge clk); #1;
        // Keep offering junk commands while busy; they must be ignored.
        drive_noise_cmd();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!reg_req_o.valid) break;
            nvld++;
            chk("req_addr", reg_req_o.addr, addr);
            chk("req_write", reg_req_o.write, wr);
            chk("req_wdata", reg_req_o.wdata, wdata);
            chk("req_wstrb", reg_req_o.wstrb, wr ? wstrb : 4'hF);
            chk("busy_cmd_ready", cmd_ready_o, 0);
            reg_rsp_i.rdata = (nvld == delay + 1) ? rdata : $urandom;
            reg_rsp_i.error = (nvld == delay + 1) ? err : 1'($urandom);
            reg_rsp_i.ready = (nvld == delay + 1);
            @(posedge clk); #1;
            reg_rsp_i.ready = 1'b0;
        end
        chk("valid_cycles", 64'(nvld), 64'(exp_n));
        chk("req_zero_after", reg_req_o, '0);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_rdata", rsp_rdata_o, exp_rdata);
            chk("rsp_error", rsp_error_o, exp_err);
            chk("rsp_timeout", rsp_timeout_o, exp_to);
            chk("resp_cmd_ready", cmd_ready_o, 0);
            chk("resp_busy", busy_o, 1);
            rsp_ready_i = (h == hold);
            reg_rsp_i = {$urandom, 1'($urandom), 1'($urandom)};
            @(posedge clk); #1;
            rsp_ready_i = 1'b0;
            if (h == hold) cmd_valid_i = 1'b0;
            reg_rsp_i = '0;
            @(negedge clk);
        end
        chk("post_rsp_valid", rsp_valid_o, 0);
        chk("post_busy", busy_o, 0);
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0; reg_rsp_i = '0;
        drive_noise_cmd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", reg_req_o, '0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_error", rsp_error_o, 0);
        chk("rst_timeout", rsp_timeout_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_o, 1);

        run_txn(48'h1000, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 0);
        run_txn(48'h2004, 1'b1, 32'h12345678, 4'h3, 5, 32'hCAFEF00D, 1'b0, 0);
        run_txn(48'h3008, 1'b0, 32'h0, 4'h0, 1000, 32'h55AA55AA, 1'b0, 0);
        run_txn(48'h300C, 1'b0, 32'h0, 4'h0, TO - 1, 32'hA5A5A5A5, 1'b0, 0);
        run_txn(48'h4000, 1'b0, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b1, 10);
        run_txn(48'h4004, 1'b1, 32'hFFFF0000, 4'hC, 1, 32'h11111111, 1'b0, 0);

        // Reset in the third BUSY cycle abandons the transfer.
        cmd_valid_i = 1'b1; cmd_addr_i = 48'h5000; cmd_write_i = 1'b0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("pre_rst_valid", reg_req_o.valid, 1);
            if (c < 3) begin @(posedge clk); #1; end
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", reg_req_o.valid, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_rdata", rsp_rdata_o, 0);
        for (int c = 0; c < 8; c++) begin
            chk("mid_rst_no_rsp", rsp_valid_o, 0);
            chk("mid_rst_cmd_ready", cmd_ready_o, 1);
            @(negedge clk);
        end

        for (int i = 0; i < 20; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? (TO - 2 + int'($urandom_range(0, 4)))
                                            : int'($urandom_range(0, 8));
            run_txn({$urandom, $urandom}, 1'($urandom), $urandom, 4'($urandom), d,
                    $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
